// File: rtl/sync_mbfifo_pkg.sv
// sync_mbfifo_pkg: shared buffer-state type, count width and index-width helper
package sync_mbfifo_pkg;

    typedef enum logic [1:0] {EMPTY, WRITING, FULL, READING} buf_state_t;

    localparam int COUNT_WIDTH = 24;

    function automatic int clog2(input int value);
        for (int w = 1; w < 31; w++)
            if ((1 << w) >= value) return w;
        return 31;
    endfunction

endpackage

// File: rtl/sync_mbfifo_ram.sv
// sync_mbfifo_ram: single-clock simple dual-port RAM with registered, resettable read port
module sync_mbfifo_ram
    import sync_mbfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 96,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage array, written only on accepted write strobes
    always_ff @(posedge clk)
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;

    // Output register holds its word until the next accepted read
    always_ff @(posedge clk or posedge rst)
        if (rst) o_rd_data <= '0;
        else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];

endmodule

// File: rtl/sync_mbfifo.sv
// sync_mbfifo: single-clock N-buffer block FIFO; commit-ordered delivery.
// Optional sticky error flags when SYNC_MBFIFO_ERROR_EN is defined.
module sync_mbfifo
    import sync_mbfifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int BUFFER_COUNT  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [BUFFER_COUNT-1:0] write_ready,
    input  logic [BUFFER_COUNT-1:0] write_activate,
    output logic [COUNT_WIDTH-1:0]  write_fifo_size,
    input  logic                    write_strobe,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    starved,
    output logic                    read_ready,
    input  logic                    read_activate,
    output logic [COUNT_WIDTH-1:0]  read_count,
    input  logic                    read_strobe,
    output logic [DATA_WIDTH-1:0]   read_data
`ifdef SYNC_MBFIFO_ERROR_EN
    ,
    output logic [2:0]              error
`endif
);

    localparam int IW = clog2(BUFFER_COUNT);
    localparam int QW = clog2(BUFFER_COUNT + 1);
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] SIZE = CW'(1) << ADDRESS_WIDTH;

    buf_state_t              r_state [BUFFER_COUNT];
    logic [CW-1:0]           r_count [BUFFER_COUNT];
    logic [IW-1:0]           r_q     [BUFFER_COUNT];
    logic [QW-1:0]           r_qn;
    logic [IW-1:0]           r_wbuf, r_rbuf;
    logic                    r_wact, r_ract;
    logic [CW-1:0]           r_rptr;
    logic [BUFFER_COUNT-1:0] r_wa_prev;
    logic                    r_ra_prev;
    logic                    r_starved;

    logic [BUFFER_COUNT-1:0] w_rise, w_cand;
    logic [IW-1:0]           w_sel, w_tail;
    logic                    w_claim, w_wrel, w_wr_en, w_push;
    logic                    w_avail, w_rclaim, w_rrel, w_rd_en;

    assign w_rise   = write_activate & ~r_wa_prev;
    assign w_cand   = w_rise & write_ready;
    assign w_wrel   = r_wact && !write_activate[r_wbuf];
    assign w_claim  = (w_cand != '0) && (!r_wact || w_wrel);
    assign w_wr_en  = r_wact && write_activate[r_wbuf] && write_strobe && (r_count[r_wbuf] < SIZE);
    assign w_push   = w_wrel && (r_count[r_wbuf] != '0);
    assign w_avail  = (r_qn != '0) && !r_ract;
    assign w_rclaim = read_activate && !r_ra_prev && w_avail;
    assign w_rrel   = r_ract && !read_activate;
    assign w_rd_en  = r_ract && read_activate && read_strobe && (r_rptr < r_count[r_rbuf]);
    assign w_tail   = IW'(r_qn - QW'(w_rclaim));

    assign read_ready      = w_avail && !read_activate;
    assign read_count      = COUNT_WIDTH'(r_ract ? r_count[r_rbuf] : (r_qn != '0 ? r_count[r_q[0]] : '0));
    assign write_fifo_size = COUNT_WIDTH'(SIZE);
    assign starved         = r_starved;

    // Ready flags and lowest-index pick among newly requested ready buffers
    always_comb begin
        write_ready = '0;
        w_sel       = '0;
        for (int i = 0; i < BUFFER_COUNT; i++) write_ready[i] = (r_state[i] == EMPTY);
        for (int i = BUFFER_COUNT - 1; i >= 0; i--) if (w_cand[i]) w_sel = IW'(i);
    end

    // Buffer lifecycle, word counts, pointers and the commit-order queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_COUNT; i++) begin
                r_state[i] <= EMPTY;
                r_count[i] <= '0;
                r_q[i]     <= '0;
            end
            r_qn      <= '0;
            r_wbuf    <= '0;
            r_rbuf    <= '0;
            r_wact    <= 1'b0;
            r_ract    <= 1'b0;
            r_rptr    <= '0;
            r_wa_prev <= '0;
            r_ra_prev <= 1'b0;
            r_starved <= 1'b1;
        end else begin
            r_wa_prev <= write_activate;
            r_ra_prev <= read_activate;
            r_starved <= (r_qn == '0) && !r_ract;
            if (w_wr_en) r_count[r_wbuf] <= r_count[r_wbuf] + 1'b1;
            if (w_wrel) begin
                r_wact          <= 1'b0;
                r_state[r_wbuf] <= w_push ? FULL : EMPTY;
            end
            if (w_claim) begin
                r_wact         <= 1'b1;
                r_wbuf         <= w_sel;
                r_state[w_sel] <= WRITING;
            end
            if (w_rclaim) begin
                r_ract          <= 1'b1;
                r_rbuf          <= r_q[0];
                r_rptr          <= '0;
                r_state[r_q[0]] <= READING;
                for (int i = 0; i < BUFFER_COUNT - 1; i++) r_q[i] <= r_q[i+1];
            end
            if (w_push) r_q[w_tail] <= r_wbuf;
            r_qn <= r_qn + QW'(w_push) - QW'(w_rclaim);
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
            if (w_rrel) begin
                r_ract          <= 1'b0;
                r_state[r_rbuf] <= EMPTY;
                r_count[r_rbuf] <= '0;
            end
        end
    end

    sync_mbfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_COUNT << ADDRESS_WIDTH),
        .AW         (IW + ADDRESS_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_wbuf, r_count[r_wbuf][ADDRESS_WIDTH-1:0]}),
        .i_wr_data (write_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr ({r_rbuf, r_rptr[ADDRESS_WIDTH-1:0]}),
        .o_rd_data (read_data)
    );

`ifdef SYNC_MBFIFO_ERROR_EN
    logic [2:0] r_error;
    logic       w_illegal;

    assign w_illegal = ((w_rise & ~write_ready) != '0) || ($countones(w_rise) > 1) ||
                       ((w_cand != '0) && !w_claim) || (read_activate && !r_ra_prev && !w_avail);
    assign error = r_error;

    // Sticky record of ignored strobes and illegal activations
    always_ff @(posedge clk or posedge rst)
        if (rst) r_error <= '0;
        else r_error <= r_error | {w_illegal, read_strobe && !w_rd_en, write_strobe && !w_wr_en};
`endif

endmodule

// File: doc/sync_mbfifo.md
Name: sync_mbfifo

Overview:
Single-clock, N-buffer successor to the dual-clock ping-pong FIFO. It keeps the same activate/ready/strobe/count handshake, generalised to BUFFER_COUNT buffers. Committed buffers are delivered to the reader strictly in commit order. It sits between single-clock-domain producers (e.g. DMA packers) and consumers that transfer in whole blocks.

Parameters:
DATA_WIDTH, 32, word width
ADDRESS_WIDTH, 5, log2 words per buffer (buffer size 2**ADDRESS_WIDTH)
BUFFER_COUNT, 3, number of buffers; legal range 2..8

Ports:
clk  in  1  single clock for both sides
rst  in  1  asynchronous, active-high reset
write_ready  out  BUFFER_COUNT  bit i high: buffer i empty and available
write_activate  in  BUFFER_COUNT  one-hot claim of a ready buffer
write_fifo_size  out  24  constant 2**ADDRESS_WIDTH
write_strobe  in  1  store write_data into the active write buffer
write_data  in  DATA_WIDTH  write word
starved  out  1  reader idle with nothing committed
read_ready  out  1  oldest committed buffer available to claim
read_activate  in  1  claim or hold the read buffer
read_count  out  24  word count of the offered/active read buffer
read_strobe  in  1  pop one word
read_data  out  DATA_WIDTH  registered read word

Behaviour:
- Reset values: write_ready all 1, read_ready 0, read_count 0, read_data 0, starved 1; all buffers EMPTY, all counts 0, commit queue empty.
- Per-buffer states: EMPTY -> WRITING -> FULL -> READING -> EMPTY.
- Write claim:
  - write_activate[i] rising while buffer i is EMPTY -> WRITING. write_ready[i] drops on the next edge.
  - Activation of a non-ready buffer is ignored.
  - If more than one bit is high, only the lowest-index ready bit is honoured.
- Write: each cycle with write_strobe and an active buffer stores the word at the write pointer and increments the count. Strobes at count == size, or with no active buffer, are ignored.
- Write release: write_activate[i] falling:
  - count > 0 -> FULL, index pushed onto the commit queue.
  - count == 0 -> EMPTY.
- Read offer:
  - read_ready = 1 when the queue is non-empty, no buffer is READING, and read_activate is low.
  - read_count shows the queue-head count.
  - read_ready rises 1 cycle after a commit.
- Read claim: read_activate rising while read_ready -> head popped, buffer READING, read_ready low next cycle. read_activate rising while read_ready is low is ignored.
- Read: read_strobe pops at the read pointer. read_data is valid 1 cycle after the strobe. Strobes past read_count are ignored and read_data holds.
- Read release: read_activate falling -> buffer EMPTY, unread words discarded, count cleared. write_ready[i] rises 1 cycle later.
- starved = registered (queue empty AND no buffer READING).
- Simultaneous events:
  - Write release and read claim in the same cycle act independently.
  - A buffer released by the reader cannot be re-claimed by the writer in that same cycle.
  - A commit and a queue pop in the same cycle are both honoured.
- Commit-queue depth is BUFFER_COUNT, so it cannot overflow.
- Reset mid-operation returns everything to reset values immediately; in-flight data is lost.
- Arithmetic: counts are ADDRESS_WIDTH+1 bits, zero-extended to 24. The RAM address is {buffer index, pointer}.

Optional Feature:
- Macro: SYNC_MBFIFO_ERROR_EN.
- Defined:
  - Adds output error[2:0], sticky until rst.
  - bit0: write_strobe ignored (full or no active buffer).
  - bit1: read_strobe ignored.
  - bit2: illegal activation (non-ready or multi-hot).
- Undefined: no port, no logic; ignored events are silent.

Decomposition:
- Shared package sync_mbfifo_pkg holds:
  - buffer state enum (EMPTY/WRITING/FULL/READING);
  - COUNT_WIDTH = 24;
  - a clog2 function for the buffer index width.
- Sub-module sync_mbfifo_ram: simple dual-port RAM, single clock, depth BUFFER_COUNT*2**ADDRESS_WIDTH, registered read.
- Control (states, counts, commit queue) stays in sync_mbfifo.

Test Plan:
Test-plan parameters: BUFFER_COUNT=3, ADDRESS_WIDTH=5.
- After reset -> write_ready=3'b111, read_ready=0, starved=1, write_fifo_size=32.
- Write 5 words 0x0123..0xaaaa to buf0, release -> read_ready next cycle, read_count=5. Reader drains 0x0123,0x4567,0x89ab,0xcdef,0xaaaa, each 1 cycle after its strobe. After release, write_ready[0]=1.
- Fill buf0, buf1, buf2 with 32 words each (values 0..31, 100..131, 200..231), reader held off -> write_ready=0 after the third claim. Reads return buf0, buf1, buf2 contents in commit order.
- Interleaved strobe/idle writes (16 words, alternating cycles) -> count=16, data contiguous.
- 40 strobes into one buffer -> count saturates at 32, words 32..39 dropped. With SYNC_MBFIFO_ERROR_EN, error[0]=1.
- Assert rst mid-read of a 32-word buffer at word 10 -> all outputs return to reset values, and the next write/read cycle operates normally.
